fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction fetch unit with a program counter and a prefetch queue. It issues sequential read requests to a synchronous instruction memory and buffers the returned words, each tagged with its address, in a DEPTH-entry FIFO. The decode stage drains the FIFO through a valid/ready handshake. A redirect input flushes the queue and restarts fetching at a new address. The block sits between instruction memory and decode, and supersedes the single-register fetch stage.

## Interface
- DATA_W, 8, instruction word width
- ADDR_W, 8, program counter / memory address width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, PC value after reset

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- enabled  in  1  fetch enable; when 0, no new memory requests are issued
- redirect  in  1  flush queue and load PC from redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- mem_req  out  1  read request this cycle (combinational)
- mem_addr  out  ADDR_W  read address; equals the PC register
- mem_data  in  DATA_W  read data, valid the cycle after a request
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts the head
- out_data  out  DATA_W  head instruction word
- out_pc  out  ADDR_W  address of the head word

## Operation
- State consists of: pc; FIFO of DEPTH × {DATA_W data, ADDR_W pc}; count (0..DEPTH); inflight flag (1 = request issued last cycle).
- Request rule: mem_req = enabled & ~redirect & (count + inflight < DEPTH). Use only registered count/inflight; a pop in the same cycle grants no credit.
- On request: pc ← pc+1, wrapping modulo 2^ADDR_W. The issued address is recorded in a one-deep pending-pc register. inflight ← 1; otherwise inflight ← 0.
- Response: when inflight=1 and redirect=0, {mem_data, pending pc} is pushed at the edge.
- Pop: out_valid & out_ready & ~redirect.
- Simultaneous push and pop: count is unchanged. The FIFO never overflows, by the request rule.
- out_valid = (count ≠ 0). out_data and out_pc come from the head entry. Contents are don't-care when out_valid=0.
- Redirect (highest priority, synchronous):
  - count ← 0 and inflight ← 0.
  - Any response arriving this cycle is discarded.
  - Any pop this cycle is ignored.
  - pc ← redirect_pc.
  - mem_req = 0 this cycle.
- enabled=0: no new requests. An in-flight response still completes and is pushed. The FIFO keeps draining.
- Reset values (immediate on reset=0, independent of clk):
  - pc=RESET_PC, count=0, inflight=0.
  - out_valid=0, out_data=0, out_pc=0.
  - mem_req=0 while reset is asserted.
  - Reset mid-operation discards all queued and in-flight words.

## Timing
- Cycle k is the period following rising edge k.
- Request in cycle k → mem_data is present in cycle k+1 → word is pushed at edge k+2 → out_valid=1 from cycle k+2. Fetch-to-output latency is 2 cycles.
- After reset release with enabled=1: first request in cycle 0 (addr RESET_PC), out_valid in cycle 2.
- Redirect sampled at end of cycle c → request to redirect_pc in cycle c+1 → out_valid with out_pc=redirect_pc in cycle c+3.
- Steady state with out_ready=1: requests issue every cycle once primed, one word is delivered per cycle, and count stays ≤2.
- With out_ready=0 the queue fills to DEPTH. mem_req drops once count+inflight=DEPTH. The first pop re-enables mem_req one cycle later.
- PC wraps: after address 2^ADDR_W−1, the next request is to address 0.

## Test plan
- Reset/startup: reset=0 for 3 cycles, then reset=1, enabled=1, out_ready=1, memory returns addr^8'hA5 → outputs (out_pc, out_data) = (00,A5), (01,A4), (02,A7)… on consecutive cycles, first valid in cycle 2.
- Backpressure: out_ready=0 for 10 cycles → count saturates at 4, mem_req=0 after 4 requests total; then out_ready=1 → pcs 00..03 pop in order, next request addr 04 the cycle after the first pop.
- Redirect with full queue and in-flight read: redirect=1, redirect_pc=8'h40 → out_valid=0 the next cycle, stale word dropped, first delivered out_pc=40 in cycle c+3, followed by 41, 42.
- Enable gating: enabled=0 while a request is in flight → that word is still delivered; no further mem_req until enabled=1, then fetching resumes at the next sequential address.
- Wrap-around: redirect_pc=8'hFE → delivered out_pc sequence FE, FF, 00, 01.
- Async reset mid-stream: drive reset=0 between clock edges with count=3 → out_valid, mem_req and count go to 0 immediately; after release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Memory-side and decode-side signals of the fetch queue.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_queue_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              enabled;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    input  enabled, redirect, redirect_pc, mem_data, out_ready,
    output mem_req, mem_addr, out_valid, out_data, out_pc
  );

  modport slave (
    output enabled, redirect, redirect_pc, mem_data, out_ready,
    input  mem_req, mem_addr, out_valid, out_data, out_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit: PC, sequential memory requests and a DEPTH-entry
// prefetch FIFO of {word, address} drained by decode through valid/ready.
module fetch_queue #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] pc, pend_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [PW-1:0]     head, tail;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic [CW:0] used;
  logic        req, push, pop;

  // Credit uses registered state only, so a same-cycle pop never frees a slot.
  assign used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req  = reset & bus.enabled & ~bus.redirect & (used < DEPTH_V);
  assign push = inflight & ~bus.redirect;
  assign pop  = (count != '0) & bus.out_ready & ~bus.redirect;

  assign bus.mem_req   = req;
  assign bus.mem_addr  = pc;
  assign bus.out_valid = (count != '0);
  // Head is forced to zero when empty so outputs read zero during reset.
  assign bus.out_data  = (count != '0) ? data_q[head] : '0;
  assign bus.out_pc    = (count != '0) ? pc_q[head]   : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      pend_pc  <= '0;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (bus.redirect) begin
      pc       <= bus.redirect_pc;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= req;
      if (req) begin
        pc      <= pc + ADDR_W'(1);
        pend_pc <= pc;
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail] <= bus.mem_data;
      pc_q[tail]   <= pend_pc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: startup vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fetch_queue;
  localparam int DW = 8, AW = 8, DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fetch_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Synchronous instruction memory: content is addr ^ A5.
  function automatic logic [7:0] memf(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction
  initial bus.mem_data = '0;
  always @(posedge clk) bus.mem_data <= memf(bus.mem_addr);

  typedef struct { logic [7:0] data; logic [7:0] pc; } ent_t;
  ent_t       q[$];
  logic [7:0] mpc, mpend;
  bit         minfl;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc   = 8'h00;
    mpend = 8'h00;
    minfl = 0;
  endtask

  // One cycle: drive at negedge, compare against model, then advance model.
  task automatic step(input logic en, input logic rd, input logic [7:0] rpc, input logic rdy);
    bit   ereq;
    ent_t e;
    @(negedge clk);
    bus.enabled = en; bus.redirect = rd; bus.redirect_pc = rpc; bus.out_ready = rdy;
    #1;
    ereq = en && !rd && (q.size() + int'(minfl) < DEPTH);
    chk("mem_req", bus.mem_req, ereq);
    chk("mem_addr", bus.mem_addr, mpc);
    chk("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_pc", bus.out_pc, q[0].pc);
      chk("out_data", bus.out_data, q[0].data);
    end
    if (rd) begin
      q.delete();
      minfl = 0;
      mpc   = rpc;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (minfl) begin
        e.data = memf(mpend); e.pc = mpend;
        q.push_back(e);
      end
      if (ereq) begin
        mpend = mpc;
        mpc   = mpc + 8'd1;
      end
      minfl = ereq;
    end
  endtask

  // Hold reset for 3 cycles (enabled high to show mem_req is gated), then release.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; bus.enabled = 1'b1; bus.redirect = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_mem_addr", bus.mem_addr, 8'h00);
    bus.enabled = 1'b0;
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic en, rd; logic [7:0] rpc; logic rdy;
    logic x_valid; logic [7:0] x_pc, x_data; logic x_req; logic [7:0] x_addr;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int         nreq;
    bit         seen;
    logic [7:0] last_addr;
    logic [7:0] got[$];
    logic [7:0] wexp[4];

    reset = 1'b0;
    bus.enabled = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;

    tbl[0] = '{1, 0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 8'h00};
    tbl[1] = '{1, 0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 8'h01};
    tbl[2] = '{1, 0, 8'h00, 1, 1, 8'h00, 8'hA5, 1, 8'h02};
    tbl[3] = '{1, 0, 8'h00, 1, 1, 8'h01, 8'hA4, 1, 8'h03};
    tbl[4] = '{1, 0, 8'h00, 1, 1, 8'h02, 8'hA7, 1, 8'h04};
    tbl[5] = '{1, 0, 8'h00, 1, 1, 8'h03, 8'hA6, 1, 8'h05};

    // Startup stream
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].en, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
      chk("tbl_valid", bus.out_valid, tbl[i].x_valid);
      chk("tbl_req", bus.mem_req, tbl[i].x_req);
      chk("tbl_addr", bus.mem_addr, tbl[i].x_addr);
      if (tbl[i].x_valid) begin
        chk("tbl_pc", bus.out_pc, tbl[i].x_pc);
        chk("tbl_data", bus.out_data, tbl[i].x_data);
      end
    end

    // Backpressure: only DEPTH requests, resume the cycle after the first pop
    do_reset();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 8'h00, 0);
      nreq += int'(bus.mem_req);
    end
    chk("bp_req_total", nreq, 4);
    step(1, 0, 8'h00, 1);
    chk("bp_first_pop_pc", bus.out_pc, 8'h00);
    chk("bp_no_req_on_pop", bus.mem_req, 0);
    step(1, 0, 8'h00, 1);
    chk("bp_resume_req", bus.mem_req, 1);
    chk("bp_resume_addr", bus.mem_addr, 8'h04);
    chk("bp_second_pc", bus.out_pc, 8'h01);
    repeat (3) step(1, 0, 8'h00, 1);

    // Redirect with 3 queued words and one read in flight
    do_reset();
    repeat (4) step(1, 0, 8'h00, 0);
    step(1, 1, 8'h40, 1);
    chk("rd_req_blocked", bus.mem_req, 0);
    step(1, 0, 8'h00, 1);
    chk("rd_flushed", bus.out_valid, 0);
    chk("rd_new_addr", bus.mem_addr, 8'h40);
    step(1, 0, 8'h00, 1);
    chk("rd_stale_dropped", bus.out_valid, 0);
    step(1, 0, 8'h00, 1);
    chk("rd_first_valid", bus.out_valid, 1);
    chk("rd_first_pc", bus.out_pc, 8'h40);
    step(1, 0, 8'h00, 1);
    chk("rd_second_pc", bus.out_pc, 8'h41);
    step(1, 0, 8'h00, 1);
    chk("rd_third_pc", bus.out_pc, 8'h42);

    // Enable gating: in-flight word still lands, no new requests
    last_addr = bus.mem_addr;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 1);
      chk("en_gate_req", bus.mem_req, 0);
      if (bus.out_valid && bus.out_pc == last_addr) seen = 1;
    end
    chk("en_inflight_delivered", seen, 1);
    step(1, 0, 8'h00, 1);
    chk("en_resume_req", bus.mem_req, 1);
    chk("en_resume_addr", bus.mem_addr, last_addr + 8'd1);

    // PC wrap-around
    step(1, 1, 8'hFE, 1);
    got.delete();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'h00, 1);
      if (bus.out_valid) got.push_back(bus.out_pc);
    end
    wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00; wexp[3] = 8'h01;
    for (int i = 0; i < 4; i++)
      chk("wrap_pc", (got.size() > i) ? got[i] : 8'hxx, wexp[i]);

    // Asynchronous reset between edges with 3 words queued
    do_reset();
    repeat (4) step(1, 0, 8'h00, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_mem_req", bus.mem_req, 0);
    chk("arst_out_pc", bus.out_pc, 0);
    chk("arst_mem_addr", bus.mem_addr, 8'h00);
    bus.enabled = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step(1, 0, 8'h00, 1);
    chk("arst_restart_addr", bus.mem_addr, 8'h00);
    chk("arst_restart_req", bus.mem_req, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
           8'($urandom), $urandom_range(0, 2) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
